riscmakers_mem_arbiter: RTL and testbench
=========================================

# riscmakers_mem_arbiter

Two-port memory request arbiter that merges instruction-cache and data-cache miss/write traffic into one registered request channel towards the memory adapter. It routes the returning responses back to the originating cache. It bounds outstanding transactions per source and sits between `cva6_icache`/`riscmakers_dcache` and the AXI memory adapter inside the cache subsystem.

## Interface
Parameters:
- `AddrWidth`, 64: physical request address width.
- `DataWidth`, 64: write and return data width.
- `IdWidth`, 4: transaction ID width, carried through unchanged.
- `MaxOutstanding`, 4: maximum in-flight requests per source, ≥1. Counter width is $clog2(MaxOutstanding+1).

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `icache_req_i`  in  1  I$ request valid.
- `icache_ack_o`  out  1  I$ request accepted this cycle.
- `icache_addr_i`  in  AddrWidth  I$ read address.
- `icache_id_i`  in  IdWidth  I$ transaction ID.
- `dcache_req_i`  in  1  D$ request valid.
- `dcache_ack_o`  out  1  D$ request accepted this cycle.
- `dcache_addr_i`  in  AddrWidth  D$ address.
- `dcache_we_i`  in  1  D$ write (1) or read (0).
- `dcache_wdata_i`  in  DataWidth  D$ write data.
- `dcache_be_i`  in  DataWidth/8  D$ byte enables.
- `dcache_id_i`  in  IdWidth  D$ transaction ID.
- `mem_req_valid_o`  out  1  registered request valid.
- `mem_req_ready_i`  in  1  adapter accepts request.
- `mem_req_src_o`  out  1  source of request: 0 = I$, 1 = D$.
- `mem_req_addr_o`, `mem_req_we_o`, `mem_req_wdata_o`, `mem_req_be_o`, `mem_req_id_o`  out  widths as above  request payload. The I$ request is forced to we=0, be=0, wdata=0.
- `mem_rtrn_valid_i`  in  1  response valid; always accepted.
- `mem_rtrn_src_i`  in  1  response destination.
- `mem_rtrn_data_i`  in  DataWidth  response data.
- `mem_rtrn_id_i`  in  IdWidth  response ID.
- `icache_rtrn_vld_o`, `dcache_rtrn_vld_o`  out  1  routed response valids.
- `rtrn_data_o`  out  DataWidth  registered response data, shared by both destinations.
- `rtrn_id_o`  out  IdWidth  registered response ID.
- `err_o`  out  1  sticky protocol error flag.

## Operation
- **Output slot:** a single register holds `mem_req_*`. The slot is free when `!mem_req_valid_o || mem_req_ready_i`.
- **Eligibility:** a source is eligible when its request is high, the slot is free, and its outstanding count is below MaxOutstanding.
- **Grant:** round-robin with a 1-bit priority pointer `prio_q`, reset value 0 (I$ first).
  - When both sources are eligible, the grant goes to `prio_q`. `prio_q` then flips to the non-granted source.
  - When a single source is eligible, it is granted and `prio_q` points to the other source.
- **Ack:** `*_ack_o` is combinational, equal to the grant. At most one ack is high per cycle. The granted payload loads into the slot on the same edge.
- **Slot hold:** while `mem_req_valid_o && !mem_req_ready_i`, the payload is held stable and no ack is issued. If the slot frees and a new grant occurs in the same cycle, the slot reloads back-to-back with no bubble.
- **Outstanding counters:** one counter per source.
  - Increment on that source's ack.
  - Decrement on `mem_rtrn_valid_i` with a matching `mem_rtrn_src_i`.
  - Increment and decrement in the same cycle on the same source leave the counter unchanged.
- **Return path:** one register stage. `src` selects which of `icache_rtrn_vld_o`/`dcache_rtrn_vld_o` pulses; the other stays 0. Data and ID are captured on every valid response and held otherwise.
- **Errors:** `err_o` sets and stays set until reset on either condition:
  - a response arrives for a source whose counter is 0; that counter stays at 0 (no underflow);
  - `mem_req_ready_i` is high while `mem_req_valid_o` is 0; this is harmless but flagged.
- **Reset mid-operation:** clears the slot, both counters, `prio_q` and `err_o` immediately. Any in-flight responses arriving after reset are treated as errors.

## Timing
- **Reset values:** all outputs 0. `mem_req_valid_o`=0, both acks 0 (requests are gated by reset), both rtrn valids 0, `err_o`=0, all payload and data registers 0.
- **Request latency:** ack at cycle N gives `mem_req_valid_o` high at N+1. Sustained throughput is one request per cycle when ready is held high.
- **Return latency:** `mem_rtrn_valid_i` at cycle N gives the routed valid at N+1, one cycle wide per input pulse.
- **Back-pressure:** a source at MaxOutstanding receives no ack until a response for it is registered. The counter decrements at the edge ending cycle N, so an ack is possible in cycle N+1.
- **Simultaneous events:** a response and a request on the same source in the same cycle, with the counter full, give no ack that cycle. The counter drops to MaxOutstanding-1 and the ack is possible next cycle.

## Test plan
- **Single I$ read:** reset, then `icache_req_i`=1, addr 0x8000_0040, id 0 → `icache_ack_o`=1 in cycle 1. `mem_req_valid_o`=1, src 0, we 0 in cycle 2. A return with src 0 and data 0xDEADBEEF → `icache_rtrn_vld_o` pulses one cycle later with `rtrn_data_o`=0xDEADBEEF.
- **Contention:** both sources request continuously with ready=1 and returns immediate → acks alternate I$, D$, I$, D$. No gap cycles on `mem_req_valid_o`.
- **Back-pressure:** hold ready=0 for 5 cycles after the first grant → payload stable, no acks. Ready=1 → next grant on the following edge.
- **Outstanding limit:** D$ issues 4 requests with no returns → the 5th request gets no ack. One D$ return → ack one cycle after the registered return.
- **Spurious return:** return with src 1 while the D$ count is 0 → `err_o`=1 next cycle and it stays set. Assert `rst_i` asynchronously → `err_o`=0 and `mem_req_valid_o`=0 without waiting for a clock edge.

Source files
------------

// File: rtl/riscmakers_mem_arbiter.sv
// riscmakers_mem_arbiter: round-robin I$/D$ request merge into one registered slot, with response routing
module riscmakers_mem_arbiter #(
    parameter int AddrWidth      = 64,
    parameter int DataWidth      = 64,
    parameter int IdWidth        = 4,
    parameter int MaxOutstanding = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   icache_req_i,
    output logic                   icache_ack_o,
    input  logic [AddrWidth-1:0]   icache_addr_i,
    input  logic [IdWidth-1:0]     icache_id_i,
    input  logic                   dcache_req_i,
    output logic                   dcache_ack_o,
    input  logic [AddrWidth-1:0]   dcache_addr_i,
    input  logic                   dcache_we_i,
    input  logic [DataWidth-1:0]   dcache_wdata_i,
    input  logic [DataWidth/8-1:0] dcache_be_i,
    input  logic [IdWidth-1:0]     dcache_id_i,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic                   mem_req_src_o,
    output logic [AddrWidth-1:0]   mem_req_addr_o,
    output logic                   mem_req_we_o,
    output logic [DataWidth-1:0]   mem_req_wdata_o,
    output logic [DataWidth/8-1:0] mem_req_be_o,
    output logic [IdWidth-1:0]     mem_req_id_o,
    input  logic                   mem_rtrn_valid_i,
    input  logic                   mem_rtrn_src_i,
    input  logic [DataWidth-1:0]   mem_rtrn_data_i,
    input  logic [IdWidth-1:0]     mem_rtrn_id_i,
    output logic                   icache_rtrn_vld_o,
    output logic                   dcache_rtrn_vld_o,
    output logic [DataWidth-1:0]   rtrn_data_o,
    output logic [IdWidth-1:0]     rtrn_id_o,
    output logic                   err_o
);
    localparam int CW = $clog2(MaxOutstanding + 1);
    localparam logic [CW-1:0] MaxCnt = CW'(MaxOutstanding);
    logic          prio_q;
    logic [CW-1:0] cnt_i_q, cnt_d_q;
    logic          slot_free, elig_i, elig_d, dec_i, dec_d, spurious;
    always_comb begin
        slot_free    = !mem_req_valid_o || mem_req_ready_i;
        elig_i       = !rst_i && icache_req_i && slot_free && (cnt_i_q < MaxCnt);
        elig_d       = !rst_i && dcache_req_i && slot_free && (cnt_d_q < MaxCnt);
        icache_ack_o = elig_i && (!elig_d || !prio_q);
        dcache_ack_o = elig_d && (!elig_i || prio_q);
        dec_i        = mem_rtrn_valid_i && !mem_rtrn_src_i && (cnt_i_q != '0);
        dec_d        = mem_rtrn_valid_i && mem_rtrn_src_i && (cnt_d_q != '0);
        spurious     = mem_rtrn_valid_i && (mem_rtrn_src_i ? (cnt_d_q == '0) : (cnt_i_q == '0));
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q          <= 1'b0;
            mem_req_valid_o <= 1'b0;
            mem_req_src_o   <= 1'b0;
            mem_req_addr_o  <= '0;
            mem_req_we_o    <= 1'b0;
            mem_req_wdata_o <= '0;
            mem_req_be_o    <= '0;
            mem_req_id_o    <= '0;
        end else begin
            if (icache_ack_o) prio_q <= 1'b1;
            else if (dcache_ack_o) prio_q <= 1'b0;
            if (slot_free) mem_req_valid_o <= icache_ack_o || dcache_ack_o;
            // I$ traffic is read-only, so its write fields are zeroed
            if (icache_ack_o) begin
                mem_req_src_o   <= 1'b0;
                mem_req_addr_o  <= icache_addr_i;
                mem_req_we_o    <= 1'b0;
                mem_req_wdata_o <= '0;
                mem_req_be_o    <= '0;
                mem_req_id_o    <= icache_id_i;
            end else if (dcache_ack_o) begin
                mem_req_src_o   <= 1'b1;
                mem_req_addr_o  <= dcache_addr_i;
                mem_req_we_o    <= dcache_we_i;
                mem_req_wdata_o <= dcache_wdata_i;
                mem_req_be_o    <= dcache_be_i;
                mem_req_id_o    <= dcache_id_i;
            end
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_i_q           <= '0;
            cnt_d_q           <= '0;
            icache_rtrn_vld_o <= 1'b0;
            dcache_rtrn_vld_o <= 1'b0;
            rtrn_data_o       <= '0;
            rtrn_id_o         <= '0;
            err_o             <= 1'b0;
        end else begin
            cnt_i_q           <= cnt_i_q + CW'(icache_ack_o) - CW'(dec_i);
            cnt_d_q           <= cnt_d_q + CW'(dcache_ack_o) - CW'(dec_d);
            icache_rtrn_vld_o <= mem_rtrn_valid_i && !mem_rtrn_src_i;
            dcache_rtrn_vld_o <= mem_rtrn_valid_i && mem_rtrn_src_i;
            if (mem_rtrn_valid_i) begin
                rtrn_data_o <= mem_rtrn_data_i;
                rtrn_id_o   <= mem_rtrn_id_i;
            end
            if (spurious || (mem_req_ready_i && !mem_req_valid_o)) err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_riscmakers_mem_arbiter.sv
// tb_riscmakers_mem_arbiter: vector table plus directed sequences for the memory request arbiter
module tb_riscmakers_mem_arbiter;
    localparam logic [63:0] IA = 64'h8000_0040;
    localparam logic [63:0] DA = 64'h0000_1000;
    localparam logic [63:0] WD = 64'h0123_4567_89AB_CDEF;
    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        icache_req_i = 0, dcache_req_i = 0, dcache_we_i = 1;
    logic        icache_ack_o, dcache_ack_o;
    logic [63:0] icache_addr_i = IA, dcache_addr_i = DA, dcache_wdata_i = WD;
    logic [7:0]  dcache_be_i = 8'hFF;
    logic [3:0]  icache_id_i = 4'd3, dcache_id_i = 4'd5, mem_req_id_o, mem_rtrn_id_i = 0, rtrn_id_o;
    logic        mem_req_valid_o, mem_req_ready_i = 0, mem_req_src_o, mem_req_we_o;
    logic [63:0] mem_req_addr_o, mem_req_wdata_o, mem_rtrn_data_i = 0, rtrn_data_o;
    logic [7:0]  mem_req_be_o;
    logic        mem_rtrn_valid_i = 0, mem_rtrn_src_i = 0;
    logic        icache_rtrn_vld_o, dcache_rtrn_vld_o, err_o;
    int          n_vec = 0, n_err = 0;

    always #5 clk_i = ~clk_i;

    riscmakers_mem_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .icache_req_i(icache_req_i), .icache_ack_o(icache_ack_o),
        .icache_addr_i(icache_addr_i), .icache_id_i(icache_id_i),
        .dcache_req_i(dcache_req_i), .dcache_ack_o(dcache_ack_o),
        .dcache_addr_i(dcache_addr_i), .dcache_we_i(dcache_we_i),
        .dcache_wdata_i(dcache_wdata_i), .dcache_be_i(dcache_be_i), .dcache_id_i(dcache_id_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_src_o(mem_req_src_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_we_o(mem_req_we_o), .mem_req_wdata_o(mem_req_wdata_o),
        .mem_req_be_o(mem_req_be_o), .mem_req_id_o(mem_req_id_o),
        .mem_rtrn_valid_i(mem_rtrn_valid_i), .mem_rtrn_src_i(mem_rtrn_src_i),
        .mem_rtrn_data_i(mem_rtrn_data_i), .mem_rtrn_id_i(mem_rtrn_id_i),
        .icache_rtrn_vld_o(icache_rtrn_vld_o), .dcache_rtrn_vld_o(dcache_rtrn_vld_o),
        .rtrn_data_o(rtrn_data_o), .rtrn_id_o(rtrn_id_o), .err_o(err_o)
    );

    typedef struct {
        logic ir, dr, rdy, rv, rs;
        logic ia, da, mv, ms, iv, dv, er;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic dr, input logic rdy, input logic rv, input logic rs);
        icache_req_i = ir; dcache_req_i = dr; mem_req_ready_i = rdy;
        mem_rtrn_valid_i = rv; mem_rtrn_src_i = rs;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic chk_payload(input string nm, input logic src);
        chk({nm, "_src"}, mem_req_src_o, src);
        chk({nm, "_addr"}, mem_req_addr_o, src ? DA : IA);
        chk({nm, "_we"}, mem_req_we_o, src);
        chk({nm, "_wdata"}, mem_req_wdata_o, src ? WD : 64'd0);
        chk({nm, "_be"}, mem_req_be_o, src ? 64'hFF : 64'd0);
        chk({nm, "_id"}, mem_req_id_o, src ? 64'd5 : 64'd3);
    endtask

    initial begin
        //        ir dr rdy rv rs   ia da mv ms iv dv er
        tbl[0] = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0};
        tbl[2] = '{1, 1, 1, 1, 0,   0, 1, 1, 1, 1, 0, 0};
        tbl[3] = '{1, 1, 1, 1, 1,   1, 0, 1, 0, 0, 1, 0};
        tbl[4] = '{1, 1, 1, 1, 0,   0, 1, 1, 1, 1, 0, 0};
        tbl[5] = '{1, 1, 0, 1, 1,   0, 0, 1, 1, 0, 1, 0};
        tbl[6] = '{1, 1, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0};
        tbl[7] = '{1, 1, 1, 0, 0,   1, 0, 1, 0, 0, 0, 0};
        tbl[8] = '{0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0};

        #2;
        chk("rst_mv", mem_req_valid_o, 0);
        chk("rst_ack", {icache_ack_o, dcache_ack_o}, 0);
        chk("rst_err", err_o, 0);
        chk("rst_data", rtrn_data_o, 0);
        chk("rst_addr", mem_req_addr_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].ir, tbl[i].dr, tbl[i].rdy, tbl[i].rv, tbl[i].rs);
            mem_rtrn_data_i = 64'hDEAD_BEEF + 64'(i);
            mem_rtrn_id_i = 4'(i);
            #1;
            chk($sformatf("v%0d_iack", i), icache_ack_o, tbl[i].ia);
            chk($sformatf("v%0d_dack", i), dcache_ack_o, tbl[i].da);
            @(posedge clk_i);
            #1;
            chk($sformatf("v%0d_mv", i), mem_req_valid_o, tbl[i].mv);
            if (tbl[i].mv) chk_payload($sformatf("v%0d", i), tbl[i].ms);
            chk($sformatf("v%0d_irv", i), icache_rtrn_vld_o, tbl[i].iv);
            chk($sformatf("v%0d_drv", i), dcache_rtrn_vld_o, tbl[i].dv);
            chk($sformatf("v%0d_err", i), err_o, tbl[i].er);
            if (tbl[i].rv) begin
                chk($sformatf("v%0d_rdata", i), rtrn_data_o, 64'hDEAD_BEEF + 64'(i));
                chk($sformatf("v%0d_rid", i), rtrn_id_o, 64'(i));
            end
            @(negedge clk_i);
        end

        // spurious return, sticky error, then asynchronous reset mid-cycle
        do_reset();
        drive(0, 0, 0, 1, 1);
        @(posedge clk_i); #1;
        chk("spur_err", err_o, 1);
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1 chk("spur_sticky", err_o, 1);
        @(negedge clk_i);
        drive(1, 0, 0, 0, 0);
        #1 chk("spur_iack", icache_ack_o, 1);
        @(posedge clk_i); #1;
        chk("spur_mv", mem_req_valid_o, 1);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_err", err_o, 0);
        chk("arst_mv", mem_req_valid_o, 0);
        chk("arst_iack", icache_ack_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(0, 0, 0, 1, 0);
        @(posedge clk_i); #1;
        chk("late_rtrn_err", err_o, 1);
        chk("late_rtrn_irv", icache_rtrn_vld_o, 1);

        // outstanding limit on D$
        do_reset();
        drive(0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("lim_ack%0d", i), dcache_ack_o, 1);
            @(negedge clk_i);
        end
        #1 chk("lim_full", dcache_ack_o, 0);
        @(negedge clk_i);
        drive(0, 1, 1, 1, 1);
        #1 chk("lim_simul", dcache_ack_o, 0);
        @(negedge clk_i);
        drive(0, 1, 1, 0, 0);
        #1;
        chk("lim_drv", dcache_rtrn_vld_o, 1);
        chk("lim_reack", dcache_ack_o, 1);
        @(negedge clk_i);
        #1 chk("lim_full2", dcache_ack_o, 0);

        // back-pressure: payload held and no acks while ready is low
        do_reset();
        drive(1, 1, 0, 0, 0);
        #1 chk("bp_first", {icache_ack_o, dcache_ack_o}, 2'b10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            #1 chk($sformatf("bp_noack%0d", i), {icache_ack_o, dcache_ack_o}, 0);
            chk($sformatf("bp_mv%0d", i), mem_req_valid_o, 1);
            chk_payload($sformatf("bp_hold%0d", i), 0);
        end
        @(negedge clk_i);
        mem_req_ready_i = 1'b1;
        #1 chk("bp_release", {icache_ack_o, dcache_ack_o}, 2'b01);
        @(posedge clk_i); #1;
        chk("bp_mv_after", mem_req_valid_o, 1);
        chk_payload("bp_after", 1);
        chk("bp_err", err_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
